// File: rtl/qspi_sram_slave.sv
// qspi_sram_slave: QPI-mode serial SRAM responder that stands in for an
// external PSRAM. The QSPI pins are oversampled on clk, quad read (0xEB) and
// quad write (0x38) frames are decoded, and an internal byte array is served.
//
// Ports:
//   clk, rst     system clock (>= 4x sck), asynchronous active-high reset
//   sck, ce_n    QSPI clock and active-low chip enable from the master
//   sio_i        quad data from the master
//   sio_o        quad data to the master, qualified by sio_oe
//   sio_oe       output enable; the top level builds the tristate
//   busy         synchronized ce_n, inverted
//   cmd_err      one-clk pulse on an unsupported command byte
//   wr_byte_cnt  saturating count of bytes written since reset
module qspi_sram_slave #(
    parameter int MEM_ABITS    = 12,
    parameter int DUMMY_CYCLES = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        ce_n,
    input  logic [3:0]  sio_i,
    output logic [3:0]  sio_o,
    output logic        sio_oe,
    output logic        busy,
    output logic        cmd_err,
    output logic [15:0] wr_byte_cnt
);

    localparam logic [7:0] CMD_RD = 8'hEB;
    localparam logic [7:0] CMD_WR = 8'h38;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

    // ---------------- input synchronizers ----------------
    logic [SYNC_STAGES-1:0]      sck_q;
    logic [SYNC_STAGES-1:0]      ce_q;
    logic [SYNC_STAGES-1:0][3:0] sio_q;
    logic                        sck_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q    <= '0;
            ce_q     <= '1;     // bus idle (deselected) out of reset
            sio_q    <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
            ce_q     <= {ce_q[SYNC_STAGES-2:0], ce_n};
            sio_q    <= {sio_q[SYNC_STAGES-2:0], sio_i};
            sck_prev <= sck_q[SYNC_STAGES-1];
        end
    end

    logic       sck_s, ce_s, sck_rise, sck_fall;
    logic [3:0] sio_s;

    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign ce_s     = ce_q[SYNC_STAGES-1];
    assign sio_s    = sio_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign busy     = ~ce_s;

    // ---------------- state and datapath registers ----------------
    state_t                 state, state_n;
    logic [7:0]             cnt, cnt_n;
    logic [23:0]            sh, sh_n;
    logic                   half, half_n;
    logic                   is_wr, is_wr_n;
    logic [MEM_ABITS-1:0]   addr, addr_n;
    logic [3:0]             sio_o_n;
    logic                   sio_oe_n, cmd_err_n;
    logic [15:0]            wcnt_n;
    logic                   mem_we;
    logic [7:0]             mem_wdata, rd_q;
    logic [7:0]             cmd_byte;
    logic [23:0]            addr_full;

    assign cmd_byte  = {sh[3:0], sio_s};
    assign addr_full = {sh[19:0], sio_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            half        <= 1'b0;
            is_wr       <= 1'b0;
            addr        <= '0;
            sio_o       <= '0;
            sio_oe      <= 1'b0;
            cmd_err     <= 1'b0;
            wr_byte_cnt <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sh          <= sh_n;
            half        <= half_n;
            is_wr       <= is_wr_n;
            addr        <= addr_n;
            sio_o       <= sio_o_n;
            sio_oe      <= sio_oe_n;
            cmd_err     <= cmd_err_n;
            wr_byte_cnt <= wcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        half_n    = half;
        is_wr_n   = is_wr;
        addr_n    = addr;
        sio_o_n   = sio_o;
        sio_oe_n  = sio_oe;
        cmd_err_n = 1'b0;
        wcnt_n    = wr_byte_cnt;
        mem_we    = 1'b0;
        mem_wdata = {sh[3:0], sio_s};

        // Deselect has priority over everything, including an sck_rise seen
        // in the same clk; a half-received write byte is simply dropped.
        if (ce_s) begin
            state_n  = IDLE;
            sio_oe_n = 1'b0;
            cnt_n    = '0;
            half_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = CMD;
                    cnt_n   = '0;
                    half_n  = 1'b0;
                end
                CMD: if (sck_rise) begin
                    sh_n = {sh[19:0], sio_s};
                    if (cnt == 8'd1) begin
                        cnt_n = '0;
                        if (cmd_byte == CMD_RD) begin
                            state_n = ADDR;
                            is_wr_n = 1'b0;
                        end else if (cmd_byte == CMD_WR) begin
                            state_n = ADDR;
                            is_wr_n = 1'b1;
                        end else begin
                            state_n   = IGNORE;
                            cmd_err_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ADDR: if (sck_rise) begin
                    sh_n = {sh[19:0], sio_s};
                    if (cnt == 8'd5) begin
                        cnt_n   = '0;
                        half_n  = 1'b0;
                        addr_n  = addr_full[MEM_ABITS-1:0];
                        state_n = is_wr ? WDATA : DUMMY;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                // The RAM read port follows addr every clk, so rd_q holds the
                // start byte long before the dummy phase ends.
                DUMMY: if (sck_rise) begin
                    if (cnt == 8'(DUMMY_CYCLES - 1)) begin
                        cnt_n   = '0;
                        state_n = RDATA;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                // Outputs move only on sck_fall. Bumping addr with the low
                // nibble lets the next byte land in rd_q a clk later, well
                // ahead of the following fall.
                RDATA: if (sck_fall) begin
                    sio_oe_n = 1'b1;
                    if (!half) begin
                        sio_o_n = rd_q[7:4];
                        half_n  = 1'b1;
                    end else begin
                        sio_o_n = rd_q[3:0];
                        addr_n  = addr + 1'b1;
                        half_n  = 1'b0;
                    end
                end
                WDATA: if (sck_rise) begin
                    if (!half) begin
                        sh_n   = {sh[19:0], sio_s};
                        half_n = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        addr_n = addr + 1'b1;
                        half_n = 1'b0;
                        if (wr_byte_cnt != 16'hFFFF) wcnt_n = wr_byte_cnt + 16'd1;
                    end
                end
                IGNORE: sio_oe_n = 1'b0;
                default: state_n = IDLE;
            endcase
        end
    end

    // Single-port RAM, synchronous read, one access per clk. Not reset.
    logic [7:0] mem [2**MEM_ABITS];

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= mem_wdata;
        rd_q <= mem[addr];
    end

endmodule

// File: tb/tb_qspi_sram_slave.sv
module tb_qspi_sram_slave;

    localparam int ABITS = 12;
    localparam int DEPTH = 1 << ABITS;
    localparam int DUMMY = 6;
    localparam int SYNC  = 2;

    logic        clk = 1'b0, rst = 1'b0, sck = 1'b0, ce_n = 1'b1;
    logic [3:0]  sio_i = 4'h0;
    logic [3:0]  sio_o;
    logic        sio_oe, busy, cmd_err;
    logic [15:0] wr_byte_cnt;

    qspi_sram_slave #(.MEM_ABITS(ABITS), .DUMMY_CYCLES(DUMMY), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
        .sio_o(sio_o), .sio_oe(sio_oe), .busy(busy), .cmd_err(cmd_err),
        .wr_byte_cnt(wr_byte_cnt)
    );

    always #5 clk = ~clk;

    // reference model: byte array with valid flags, wrap by modulo DEPTH
    logic [7:0] mm [DEPTH];
    bit         mv [DEPTH];
    int         exp_wcnt = 0;
    logic [7:0] wq [$];
    int         h = 2;          // sck half period in clk cycles
    int         n_chk = 0, n_fail = 0;
    int         err_cnt = 0;
    bit         oe_watch = 0, oe_hit = 0;

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cnt++;
        if (oe_watch && sio_oe !== 1'b0) oe_hit = 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nib_out(input logic [3:0] n);
        sio_i = n;
        repeat (h) @(negedge clk);
        sck = 1'b1;
        repeat (h) @(negedge clk);
        sck = 1'b0;
    endtask

    // sample just before the sck fall that ends this cycle
    task automatic nib_in(output logic [3:0] n, output logic oe);
        sio_i = 4'h0;
        repeat (h) @(negedge clk);
        sck = 1'b1;
        repeat (h) @(negedge clk);
        n  = sio_o;
        oe = sio_oe;
        sck = 1'b0;
    endtask

    task automatic frame_begin(input logic [7:0] cmd, input logic [23:0] a);
        ce_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_hi", busy, 1);
        nib_out(cmd[7:4]);
        nib_out(cmd[3:0]);
        for (int i = 5; i >= 0; i--) nib_out(a[i*4 +: 4]);
    endtask

    task automatic frame_end();
        sio_i = 4'h0;
        repeat (h) @(negedge clk);
        ce_n = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        chk("busy_lo", busy, 0);
    endtask

    task automatic do_write(input int a, input bit partial, input logic [3:0] pnib);
        frame_begin(8'h38, 24'(a));
        for (int i = 0; i < wq.size(); i++) begin
            nib_out(wq[i][7:4]);
            nib_out(wq[i][3:0]);
            mm[(a + i) % DEPTH] = wq[i];
            mv[(a + i) % DEPTH] = 1'b1;
            if (exp_wcnt < 16'hFFFF) exp_wcnt++;
        end
        if (partial) nib_out(pnib);
        frame_end();
        chk("wcnt", wr_byte_cnt, exp_wcnt);
    endtask

    task automatic do_read(input int a, input int n);
        logic [3:0] hi, lo;
        logic       oe1, oe2;
        frame_begin(8'hEB, 24'(a));
        for (int d = 0; d < DUMMY; d++) nib_out(4'($urandom));
        #1 chk("oe_pre", sio_oe, 0);
        for (int i = 0; i < n; i++) begin
            nib_in(hi, oe1);
            nib_in(lo, oe2);
            chk("rd_oe", {oe1, oe2}, 2'b11);
            if (mv[(a + i) % DEPTH]) chk($sformatf("rd@%03h", (a + i) % DEPTH), {hi, lo}, mm[(a + i) % DEPTH]);
        end
        frame_end();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [3:0] n4;
        logic       o1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sio_o", sio_o, 0);
        chk("rst_sio_oe", sio_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_wcnt", wr_byte_cnt, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // basic write then read
        wq = '{8'hA5, 8'h3C};
        do_write(32'h10, 0, 4'h0);
        chk("wcnt_two", wr_byte_cnt, 2);
        do_read(32'h10, 2);

        // wrap at top of memory
        wq = '{8'h11, 8'h22};
        do_write(32'hFFF, 0, 4'h0);
        do_read(32'hFFF, 2);
        do_read(32'h000, 1);

        // partial trailing byte is dropped
        wq = '{8'hC3};
        do_write(32'h21, 0, 4'h0);
        wq = '{8'h7E};
        do_write(32'h20, 1, 4'h9);
        do_read(32'h20, 2);

        // unsupported command
        e0 = err_cnt;
        oe_hit = 0;
        oe_watch = 1;
        ce_n = 1'b0;
        repeat (4) @(negedge clk);
        nib_out(4'h9);
        nib_out(4'hF);
        for (int i = 0; i < 8; i++) nib_out(4'($urandom));
        frame_end();
        oe_watch = 0;
        chk("cmd_err_pulses", err_cnt - e0, 1);
        chk("bad_oe", oe_hit, 0);
        chk("bad_wcnt", wr_byte_cnt, exp_wcnt);
        do_read(32'h10, 2);

        // reset during read data
        frame_begin(8'hEB, 24'h10);
        for (int d = 0; d < DUMMY; d++) nib_out(4'h0);
        nib_in(n4, o1);
        chk("pre_rst_nib", n4, 4'hA);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_oe", sio_oe, 0);
        chk("rst_async_busy", busy, 0);
        ce_n = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_wcnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_wcnt2", wr_byte_cnt, 0);
        do_read(32'h10, 2);

        // randomized bursts at assorted sck rates
        for (int t = 0; t < 6; t++) begin
            int a, len;
            h = $urandom_range(2, 4);
            a = (t == 0) ? 32'hFFD : int'($urandom_range(0, DEPTH - 1));
            len = $urandom_range(1, 8);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
            do_write(a, 1'($urandom), 4'($urandom));
            do_read(a, len);
        end

        // full-speed 256-byte burst
        h = 2;
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(8'(i));
        do_write(32'h100, 0, 4'h0);
        do_read(32'h100, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
